// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_edge_filter.sv
// Synchroniser plus glitch filter for the PS/2 clock pin.
// o_fall pulses one cycle after the filtered level drops to 0.
module ps2_edge_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_pin,
   output logic o_level,
   output logic o_fall
);

   localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   filt_q, filt_d;
   logic                   prev_q, prev_d;
   logic                   fall_q, fall_d;
   logic                   sample;

   assign sample = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = i_pin;
      cnt_d     = '0;
      filt_d    = filt_q;
      // The level only flips once FILT_LEN samples in a row disagree with it.
      if (sample != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_d = sample;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      prev_d = filt_q;
      fall_d = prev_q & ~filt_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= '1;
         cnt_q  <= '0;
         filt_q <= 1'b1;
         prev_q <= 1'b1;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
         prev_q <= prev_d;
         fall_q <= fall_d;
      end
   end

   assign o_level = filt_q;
   assign o_fall  = fall_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 packets and folds E0/F0 prefixes
// into single-cycle key events. Receive only; the PS/2 pins are never driven.
module ps2_key_receiver
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 8,
   parameter int TIMEOUT     = 24000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_dat,
   output logic       o_valid,
   output logic [7:0] o_code,
   output logic       o_extended,
   output logic       o_released,
   output logic       o_err,
   output logic       o_busy
);

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic clk_level, clk_fall, fall;
   logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
   logic dat;

   ps2_state_e      state_q, state_d;
   logic [3:0]      bitcnt_q, bitcnt_d;
   logic [7:0]      sh_q, sh_d;
   logic            par_q, par_d;
   logic [TO_W-1:0] tocnt_q, tocnt_d;
   logic            ext_q, ext_d;
   logic            brk_q, brk_d;
   logic            valid_q, valid_d;
   logic [7:0]      code_q, code_d;
   logic            extd_q, extd_d;
   logic            rel_q, rel_d;
   logic            err_q, err_d;

   ps2_edge_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_clk_filter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_pin   (i_ps2_clk),
      .o_level (clk_level),
      .o_fall  (clk_fall)
   );

   // The filtered level is still low whenever a genuine fall is reported.
   assign fall = clk_fall & ~clk_level;
   assign dat  = dsync_q[SYNC_STAGES-1];

   always_comb begin
      dsync_d    = dsync_q << 1;
      dsync_d[0] = i_ps2_dat;

      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      sh_d     = sh_q;
      par_d    = par_q;
      ext_d    = ext_q;
      brk_d    = brk_q;
      valid_d  = 1'b0;
      code_d   = code_q;
      extd_d   = extd_q;
      rel_d    = rel_q;
      err_d    = 1'b0;
      tocnt_d  = (state_q == IDLE || fall) ? '0 : tocnt_q + TO_W'(1);

      if (fall) begin
         unique case (state_q)
            IDLE: begin
               if (!dat) begin
                  state_d  = DATA;
                  bitcnt_d = 4'd0;
               end
            end
            DATA: begin
               sh_d     = {dat, sh_q[7:1]};
               bitcnt_d = bitcnt_q + 4'd1;
               if (bitcnt_q == 4'd7) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               par_d   = dat;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (dat && (^{sh_q, par_q})) begin
                  if (sh_q == PS2_EXT) begin
                     ext_d = 1'b1;
                  end else if (sh_q == PS2_BRK) begin
                     brk_d = 1'b1;
                  end else begin
                     valid_d = 1'b1;
                     code_d  = sh_q;
                     extd_d  = ext_q;
                     rel_d   = brk_q;
                     ext_d   = 1'b0;
                     brk_d   = 1'b0;
                  end
               end else begin
                  err_d = 1'b1;
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && tocnt_q == TO_LAST) begin
         // A fall in the same cycle takes the branch above, so no error then.
         err_d   = 1'b1;
         state_d = IDLE;
         ext_d   = 1'b0;
         brk_d   = 1'b0;
         tocnt_d = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dsync_q  <= '1;
         state_q  <= IDLE;
         bitcnt_q <= '0;
         sh_q     <= '0;
         par_q    <= 1'b0;
         tocnt_q  <= '0;
         ext_q    <= 1'b0;
         brk_q    <= 1'b0;
         valid_q  <= 1'b0;
         code_q   <= '0;
         extd_q   <= 1'b0;
         rel_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         dsync_q  <= dsync_d;
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         sh_q     <= sh_d;
         par_q    <= par_d;
         tocnt_q  <= tocnt_d;
         ext_q    <= ext_d;
         brk_q    <= brk_d;
         valid_q  <= valid_d;
         code_q   <= code_d;
         extd_q   <= extd_d;
         rel_q    <= rel_d;
         err_q    <= err_d;
      end
   end

   assign o_valid    = valid_q;
   assign o_code     = code_q;
   assign o_extended = extd_q;
   assign o_released = rel_q;
   assign o_err      = err_q;
   assign o_busy     = (state_q != IDLE);

endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

Receives PS/2 keyboard frames from the `PS2_CLK`/`PS2_DAT` pins and turns each make or break code into a single-cycle key event. Runs on the 12 MHz audio clock domain. Sits between the board pins and `Top`'s keyboard state machine, which consumes `o_valid`, `o_code`, `o_extended` and `o_released`. The block is receive-only: the top level never drives the PS/2 lines.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in each pin synchroniser.
- `FILT_LEN`, default 8: consecutive equal samples required before the filtered PS/2 clock changes.
- `TIMEOUT`, default 24000: cycles without a PS/2 clock falling edge before a partial frame is abandoned (2 ms at 12 MHz).
- `i_clk`  in  1  system clock, 12 MHz.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_ps2_clk`  in  1  raw PS/2 clock pin, asynchronous to `i_clk`.
- `i_ps2_dat`  in  1  raw PS/2 data pin, asynchronous to `i_clk`.
- `o_valid`  out  1  one-cycle pulse: a key event is present on the outputs below.
- `o_code`  out  8  scan code, held until the next `o_valid`.
- `o_extended`  out  1  an E0 prefix preceded this code; held with `o_code`.
- `o_released`  out  1  an F0 prefix preceded this code (break); held with `o_code`.
- `o_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.
- `o_busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- **Clock path.** `i_ps2_clk` goes through `SYNC_STAGES` flip-flops, then the glitch filter. The filtered value flips only after `FILT_LEN` consecutive synchronised samples disagree with it. `fall` is a one-cycle pulse on each filtered 1→0 transition. Reset value of the filtered clock: 1.
- **Data path.** `i_ps2_dat` goes through `SYNC_STAGES` flip-flops only, with no filter. It is sampled only on `fall`.
- **Frame format.** Start bit (0), 8 data bits LSB-first, odd parity, stop bit (1). 11 falling edges in total.
- **State machine.** Transitions happen only on `fall` unless noted.
  - IDLE: if data = 0, go to DATA with `bitcnt` = 0. If data = 1 (false start), stay in IDLE with no error.
  - DATA: shift data into `sh[7:0]` from the MSB end; `bitcnt`++. After the 8th bit, go to PARITY.
  - PARITY: capture `par`; go to STOP.
  - STOP: check the frame, then go to IDLE.
    - Good frame: data = 1 and `^{sh, par}` = 1.
    - Bad frame: `o_err` pulses, the `ext` and `brk` flags clear, and no event is emitted.
- **Byte handling on a good frame.**
  - `sh` = E0: set `ext`; no event.
  - `sh` = F0: set `brk`; no event.
  - Any other value: `o_valid` = 1; `o_code` = `sh`, `o_extended` = `ext`, `o_released` = `brk`; then clear `ext` and `brk`.
- **Timeout.**
  - `tocnt` resets to 0 on every `fall` and whenever state = IDLE; otherwise it increments.
  - When `tocnt` reaches `TIMEOUT - 1` outside IDLE: `o_err` pulses, state goes to IDLE, and `ext`/`brk` clear.
  - `fall` in the same cycle as the timeout: the edge wins and no error is raised.
- **Reset values.** All outputs 0. State IDLE. `sh`, `bitcnt`, `tocnt`, `ext`, `brk` all 0.
- **Reset mid-frame.** The partial frame is discarded with no pulse on any output.
- **Widths.**
  - `bitcnt` is 4 bits.
  - `tocnt` is `$clog2(TIMEOUT)` bits and saturates logically: it never wraps, because the timeout returns the FSM to IDLE first.

## Timing
- `fall` occurs `SYNC_STAGES + FILT_LEN + 1` cycles after the pin's falling edge (11 cycles with defaults). The PS/2 half-period is at least 30 µs (360 cycles), so data is stable when sampled.
- `o_valid` and `o_err` are registered: they assert in the cycle after the `fall` that samples the stop bit, and stay high for exactly 1 cycle.
- `o_code`, `o_extended` and `o_released` update in the same cycle that `o_valid` rises.
- There is no back-pressure. The consumer must accept each `o_valid` pulse. The minimum spacing between events is one frame time (about 0.66 ms).
- `o_valid` and `o_err` are never high in the same cycle.

## Structure
- Package `ps2_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e`;
  - `localparam PS2_EXT = 8'hE0`, `PS2_BRK = 8'hF0`.
- Sub-module `ps2_edge_filter` (parameters `SYNC_STAGES`, `FILT_LEN`): synchroniser plus glitch filter, with outputs for the filtered level and the `fall` pulse. Instantiated once, for the PS/2 clock.
- The top level (outside this block) leaves `PS2_CLK` and `PS2_DAT` tri-stated and feeds them to `i_ps2_clk` and `i_ps2_dat`.

## Test plan
- Stimulus: a 1C frame at a 12.5 kHz PS/2 clock. Required response: one `o_valid`, `o_code` = 1C, `o_extended` = 0, `o_released` = 0, `o_busy` low afterwards.
- Stimulus: F0 then 1C. Required response: exactly one `o_valid` (none for F0), `o_code` = 1C, `o_released` = 1. A following 1C gives `o_released` = 0.
- Stimulus: E0, F0, 75. Required response: one `o_valid`, `o_code` = 75, `o_extended` = 1, `o_released` = 1.
- Stimulus: F0 with even parity, then 1C. Required response: `o_err` pulses once with no `o_valid`; the next 1C gives `o_released` = 0.
- Stimulus: a 5-cycle low glitch on `i_ps2_clk` in IDLE, then 5 bits of a frame, then silence. Required response: the glitch causes no `o_busy`; after 24000 idle cycles `o_err` pulses once; a subsequent 1C frame decodes correctly.
- Stimulus: assert `i_rst_n` = 0 after 6 bits of a frame, then release it and send 29. Required response: no `o_valid` or `o_err` from the partial frame; the 29 frame gives `o_valid` with `o_code` = 29.
